// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } sa_state_t;

endpackage

// File: rtl/ha_cell.sv
// Combinational half adder; two of these plus an OR form the serial full adder.
module ha_cell (
  input  logic X,
  input  logic Y,
  output logic S,
  output logic C
);

  assign S = X ^ Y;
  assign C = X & Y;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell swept LSB-first over WIDTH bits.
// Optional subtract mode (SUB port) is built when SERIAL_ADD_SUB_EN is defined.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             SUB,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        state, state_nxt;
  logic [WIDTH-1:0] opa, opb, res, res_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             load, step, finish;
  logic             sub_sel;
  logic             ha0_s, ha0_c, ha1_c;
  logic             fa_s, fa_c;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = SUB;
`else
  assign sub_sel = 1'b0;
`endif

  // Full adder on the current LSBs: (a ^ b) first, then fold in the carry.
  ha_cell u_ha0 (
    .X (opa[0]),
    .Y (opb[0]),
    .S (ha0_s),
    .C (ha0_c)
  );

  ha_cell u_ha1 (
    .X (ha0_s),
    .Y (carry),
    .S (fa_s),
    .C (ha1_c)
  );

  assign fa_c = ha0_c | ha1_c;

  // New sum bit enters at the MSB so the LSB-first stream lands in order.
  assign res_nxt = (res >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (START) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish    = 1'b1;
          state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status flags registered from the next state so they align with the state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      BUSY <= (state_nxt != IDLE);
      DONE <= (state_nxt == FIN);
    end
  end

  // Operand shifters, carry, counter and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      SUM   <= '0;
      COUT  <= 1'b0;
    end else if (load) begin
      opa   <= A;
      opb   <= sub_sel ? ~B : B;
      carry <= sub_sel;
      cnt   <= '0;
    end else if (step) begin
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
      res   <= res_nxt;
      if (finish) begin
        SUM  <= res_nxt;
        COUT <= fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8); subtract cases under SERIAL_ADD_SUB_EN.
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           acc;
  } exp_t;

  logic         CLK, RST, START;
  logic [W-1:0] A, B;
`ifdef SERIAL_ADD_SUB_EN
  logic         SUB;
`endif
  logic         BUSY, DONE, COUT;
  logic [W-1:0] SUM;

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     last_done = -100;
  logic [W-1:0] held_sum = '0;
  logic         held_cout = 1'b0;
  exp_t   q[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
`ifdef SERIAL_ADD_SUB_EN
    .SUB   (SUB),
`endif
    .BUSY  (BUSY),
    .DONE  (DONE),
    .SUM   (SUM),
    .COUT  (COUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input int acc);
    exp_t e;
    int   ia = int'(a);
    int   ib = int'(b);
    if (sub) begin
      e.sum  = W'((ia - ib + 256) % 256);
      e.cout = (ia >= ib);
    end else begin
      e.sum  = W'((ia + ib) % 256);
      e.cout = ((ia + ib) >= 256);
    end
    e.acc = acc;
    return e;
  endfunction

  // Monitor: checks DONE timing, BUSY window and held SUM/COUT after every edge.
  initial begin
    bit   exp_done, exp_busy;
    exp_t e;
    forever begin
      @(posedge CLK);
      cyc++;
      #2;
      exp_done = (q.size() > 0) && (cyc == q[0].acc + W);
      chk("done", 32'(DONE), 32'(exp_done));
      if (exp_done) begin
        e         = q.pop_front();
        held_sum  = e.sum;
        held_cout = e.cout;
        last_done = cyc;
      end
      exp_busy = ((q.size() > 0) && (cyc >= q[0].acc)) || (cyc == last_done);
      chk("busy", 32'(BUSY), 32'(exp_busy));
      chk("sum", 32'(SUM), 32'(held_sum));
      chk("cout", 32'(COUT), 32'(held_cout));
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (!BUSY) return;
    end
    chk("idle_wait", 32'(BUSY), 32'd0);
  endtask

  task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    A = a;
    B = b;
`ifdef SERIAL_ADD_SUB_EN
    SUB = sub;
`endif
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    wait_idle();
    START = 1'b1;
    drive_ops(a, b, sub);
    q.push_back(model(a, b, sub, cyc + 1));
    @(negedge CLK);
    START = 1'b0;
    drive_ops(W'($urandom), W'($urandom), 1'($urandom));
  endtask

  initial begin
    int   a1;
    logic sub_r;
    RST   = 1'b1;
    START = 1'b0;
    drive_ops('0, '0, 1'b0);
    repeat (2) @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_sum", 32'(SUM), 32'd0);
    chk("rst_cout", 32'(COUT), 32'd0);
    RST = 1'b0;

    issue(8'h5A, 8'h3C, 1'b0);
    issue(8'hFF, 8'h01, 1'b0);
    issue(8'h00, 8'h00, 1'b0);

    // START held high; operands change mid-run; second accept only back in IDLE.
    wait_idle();
    START = 1'b1;
    drive_ops(8'h01, 8'h02, 1'b0);
    a1 = cyc + 1;
    q.push_back(model(8'h01, 8'h02, 1'b0, a1));
    repeat (4) @(negedge CLK);
    drive_ops(8'h10, 8'h20, 1'b0);
    q.push_back(model(8'h10, 8'h20, 1'b0, a1 + W + 2));
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (cyc >= a1 + W + 2) break;
    end
    START = 1'b0;

    // Reset in the 4th RUN cycle aborts without DONE and clears the result.
    wait_idle();
    START = 1'b1;
    drive_ops(8'h77, 8'h11, 1'b0);
    q.push_back(model(8'h77, 8'h11, 1'b0, cyc + 1));
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    q.delete();
    held_sum  = '0;
    held_cout = 1'b0;
    last_done = -100;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_sum", 32'(SUM), 32'd0);
    issue(8'h12, 8'h34, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    issue(8'h10, 8'h01, 1'b1);
    issue(8'h00, 8'h01, 1'b1);
`endif

    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge CLK);
`ifdef SERIAL_ADD_SUB_EN
      sub_r = 1'($urandom);
`else
      sub_r = 1'b0;
`endif
      issue(W'($urandom), W'($urandom), sub_r);
    end

    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      @(negedge CLK);
    end
    chk("drain", 32'(q.size()), 32'd0);
    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller. It sequences one full-adder cell, built from two `ha_cell` half adders plus an OR, across two WIDTH-bit operands, one bit per clock, LSB first. It sits between a requester, which issues START with the operands, and the consumer, which waits for a one-cycle DONE pulse and then reads SUM/COUT. This trades adder area for WIDTH+1 cycles of latency.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range ≥1.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, synchronous and active-high.
- START  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- SUB  input  1  subtract select; present only with SERIAL_ADD_SUB_EN; captured with A/B.
- BUSY  output  1  high in RUN and DONE states.
- DONE  output  1  one-cycle pulse; result valid.
- SUM  output  WIDTH  result register.
- COUT  output  1  final carry out (no-borrow flag when subtracting).

## Operation
- States are IDLE, RUN and FIN.
- **IDLE:**
  - If START=1 at an edge, load shift regs `opa`←A and `opb`←B, set carry←0, set bit counter←0, go to RUN.
  - Otherwise stay in IDLE.
- **RUN:** each edge
  - Computes s = opa[0]^opb[0]^carry and c = majority of those three, using two `ha_cell` instances plus an OR.
  - Shifts s into the result shift reg from the MSB end.
  - Shifts opa/opb right by 1, sets carry←c, and increments the counter.
  - On the edge where the counter reaches WIDTH-1, goes to FIN. SUM←the final shifted result and COUT←c are written on that same edge.
- **FIN:** DONE=1 for exactly this one cycle. Next edge always goes to IDLE.
- START is ignored in RUN and FIN. There is no queuing; the requester must re-assert START in IDLE.
- SUM/COUT change only on the edge entering FIN. They hold until the next completion and are not disturbed by a new START.
- Width rules:
  - Counter width is $clog2(WIDTH) (min 1).
  - Result is A+B mod 2^WIDTH; COUT is bit WIDTH of the true sum.
- WIDTH=1: RUN lasts one cycle.

## Timing
- Reset values: state IDLE, BUSY=0, DONE=0, SUM=0, COUT=0. Internal shift regs, carry and counter are also cleared.
- RST has priority over everything. Asserting it mid-RUN aborts with no DONE and clears SUM/COUT to 0.
- Latency, with edge 0 being the accepting START edge:
  - BUSY is high from after edge 0 through the cycle after edge WIDTH.
  - DONE is high for the one cycle between edge WIDTH and edge WIDTH+1.
  - Next START is accepted at edge WIDTH+2 at the earliest.
- Throughput: one operation per WIDTH+2 cycles.
- A and B are don't-care except on the accepting edge.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - SUB port exists and is captured on the accepting edge.
  - SUB=1 loads opb←~B and carry←1, giving SUM = A-B mod 2^WIDTH. COUT=1 means A≥B (no borrow).
  - SUB=0 gives identical behaviour to the undefined case.
- SERIAL_ADD_SUB_EN undefined: SUB port absent; add only; carry always starts at 0.

## Structure
- Package `serial_add_pkg` holds:
  - state enum typedef `sa_state_t` {IDLE, RUN, FIN};
  - constant DEFAULT_WIDTH=8.
- Sub-module `ha_cell`: combinational half adder, ports S, C, X, Y. It is instantiated twice to form the per-bit full adder.
- All sequencing, shift registers and the counter live in `serial_add_ctrl`.

## Test plan
- **Reset values:** assert RST for 2 cycles → BUSY=0, DONE=0, SUM=0x00, COUT=0.
- **Basic add:** WIDTH=8, A=0x5A, B=0x3C, START one cycle → DONE pulses exactly 8 edges after acceptance for one cycle; SUM=0x96, COUT=0.
- **Carry out:** A=0xFF, B=0x01 → SUM=0x00, COUT=1. Back-to-back A=0x00, B=0x00 issued at the first legal cycle → SUM=0x00, COUT=0.
- **START while busy:** START held high continuously with A=0x01, B=0x02, then operands changed to 0x10/0x20 mid-RUN →
  - the first result is SUM=0x03;
  - the next accepted START occurs only when back in IDLE and yields 0x30;
  - SUM holds 0x03 until that completion.
- **Reset mid-operation:** RST asserted in the 4th RUN cycle → next cycle is IDLE with SUM=0, COUT=0, and no DONE pulse. A following START computes correctly.
- **With SERIAL_ADD_SUB_EN:**
  - SUB=1, A=0x10, B=0x01 → SUM=0x0F, COUT=1.
  - SUB=1, A=0x00, B=0x01 → SUM=0xFF, COUT=0.
